// File: rtl/minirisc_seq_if.sv
// Instruction-issue and store-load bus of the minirisc program sequencer.
//   load_we/load_addr/load_data : host write port into the instruction store
//   instr_valid/instr_op/instr_arg : instruction presented to the core
//   core_ready : core accepts the presented instruction this cycle
// master = sequencer side, slave = host/core side.
interface minirisc_seq_if #(
  parameter int unsigned AW = 4
);
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic          instr_valid;
  logic [7:0]    instr_op;
  logic [7:0]    instr_arg;
  logic          core_ready;

  modport master (
    input  load_we, load_addr, load_data, core_ready,
    output instr_valid, instr_op, instr_arg
  );

  modport slave (
    output load_we, load_addr, load_data, core_ready,
    input  instr_valid, instr_op, instr_arg
  );
endinterface

// File: rtl/minirisc_seq.sv
// Program sequencer for the minirisc accumulator core. Holds a DEPTH x 16 instruction
// store loaded over the bus write port and issues entries to the core over a
// valid/ready handshake, with free-run, single-step, breakpoint and halt/resume control.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (master)    : load port in, instruction handshake out
//   start, abort    : run/resume pulse, return-to-idle pulse
//   step_mode       : halt after every issued instruction
//   halt_req        : stop at the next instruction boundary
//   brk_en/brk_addr : halt before issuing the instruction at brk_addr
//   pc, state       : next address to issue, IDLE=0 FETCH=1 ISSUE=2 HALT=3 DONE=4
//   issue_cnt       : instructions issued since the last start from address 0 (wraps)
//   load_err        : sticky, a write was attempted while running
module minirisc_seq #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  minirisc_seq_if.master bus,
  input  logic           start,
  input  logic           step_mode,
  input  logic           halt_req,
  input  logic           abort,
  input  logic           brk_en,
  input  logic [AW-1:0]  brk_addr,
  output logic [AW-1:0]  pc,
  output logic [2:0]     state,
  output logic [7:0]     issue_cnt,
  output logic           load_err
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StIssue = 3'd2,
    StHalt  = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    arg_q, arg_d;
  logic          valid_q;
  logic          err_q, err_d;
  logic [15:0]   mem_q [DEPTH];

  logic          wr_ok;
  logic          last_slot;
  logic [AW-1:0] pc_inc;

  // The store is only writable while nothing is in flight.
  assign wr_ok     = (state_q == StIdle) || (state_q == StHalt) || (state_q == StDone);
  assign last_slot = (pc_q == AW'(DEPTH - 1));
  assign pc_inc    = pc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    arg_d   = arg_q;
    err_d   = err_q | (bus.load_we & ~wr_ok);

    if (abort) begin
      state_d = StIdle;
      pc_d    = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StFetch;
            pc_d    = '0;
            cnt_d   = '0;
          end
        end
        StHalt: begin
          if (start) state_d = StFetch;
        end
        StFetch: begin
          {op_d, arg_d} = mem_q[pc_q];
          state_d       = halt_req ? StHalt : StIssue;
        end
        StIssue: begin
          if (bus.core_ready) begin
            cnt_d = cnt_q + 8'd1;
            if (op_q == 8'h00 || last_slot) begin
              state_d = StDone;
            end else begin
              pc_d = pc_inc;
              // Breakpoint compares the new pc only, so resuming at brk_addr
              // issues that instruction before it can trigger again.
              if (step_mode || halt_req || (brk_en && pc_inc == brk_addr)) begin
                state_d = StHalt;
              end else begin
                state_d = StFetch;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      arg_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      valid_q <= (state_d == StIssue);
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (bus.load_we && wr_ok) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.instr_valid = valid_q;
  assign bus.instr_op    = op_q;
  assign bus.instr_arg   = arg_q;
  assign pc              = pc_q;
  assign state           = state_q;
  assign issue_cnt       = cnt_q;
  assign load_err        = err_q;

endmodule

// File: tb/tb_minirisc_seq.sv
// Self-checking bench for minirisc_seq: directed scenarios, a transaction-level model
// of the expected issue stream, and a per-cycle compare process on the handshake.
module tb_minirisc_seq;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, step_mode, halt_req, abort, brk_en;
  logic [AW-1:0] brk_addr;
  logic [AW-1:0] pc;
  logic [2:0]    state;
  logic [7:0]    issue_cnt;
  logic          load_err;

  minirisc_seq_if #(.AW(AW)) bus ();

  minirisc_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .start     (start),
    .step_mode (step_mode),
    .halt_req  (halt_req),
    .abort     (abort),
    .brk_en    (brk_en),
    .brk_addr  (brk_addr),
    .pc        (pc),
    .state     (state),
    .issue_cnt (issue_cnt),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // ---------------- model ----------------
  typedef struct {
    int pc;
    int op;
    int arg;
    int cnt;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [15:0] mem_m [DEPTH];
  int          m_pc, m_cnt, m_state;

  // Walk the program from pc0 and queue every instruction that must be issued.
  function automatic void model_run(input int pc0, input int cnt0, input bit step,
                                    input bit brk, input int brk_a);
    int    p;
    int    c;
    xfer_t t;
    p = pc0;
    c = cnt0;
    m_state = 4;
    for (int n = 0; n <= DEPTH; n++) begin
      t.pc  = p;
      t.op  = int'(mem_m[p][15:8]);
      t.arg = int'(mem_m[p][7:0]);
      t.cnt = c;
      exp_q.push_back(t);
      c = (c + 1) % 256;
      if (t.op == 0 || p == DEPTH - 1) begin
        m_state = 4;
        break;
      end
      p++;
      if (step || (brk && p == brk_a)) begin
        m_state = 3;
        break;
      end
    end
    m_pc  = p;
    m_cnt = c;
  endfunction

  // ---------------- per-cycle compare ----------------
  int          n_xfer = 0;
  bit          gap_en = 0;
  int          last_x = -1;
  bit          pend   = 0;
  logic [7:0]  pend_op, pend_arg;
  bit          cx;
  xfer_t       ct;

  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else begin
      cx = bus.instr_valid && bus.core_ready && !abort;
      check("valid_iff_issue", int'(bus.instr_valid), int'(state == 3'd2));
      if (pend) begin
        check("stall_valid", int'(bus.instr_valid), 1);
        check("stall_op", int'(bus.instr_op), int'(pend_op));
        check("stall_arg", int'(bus.instr_arg), int'(pend_arg));
      end
      if (cx) begin
        check("xfer_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ct = exp_q.pop_front();
          check("xfer_op", int'(bus.instr_op), ct.op);
          check("xfer_arg", int'(bus.instr_arg), ct.arg);
          check("xfer_pc", int'(pc), ct.pc);
          check("xfer_cnt", int'(issue_cnt), ct.cnt);
        end
        if (gap_en && last_x >= 0) check("xfer_gap", cyc - last_x, 2);
        last_x = cyc;
        n_xfer++;
      end
      pend     = bus.instr_valid && !cx && !abort;
      pend_op  = bus.instr_op;
      pend_arg = bus.instr_arg;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    bus.load_we   = 1'b1;
    bus.load_addr = AW'(a);
    bus.load_data = d;
    tick();
    bus.load_we   = 1'b0;
    mem_m[a]      = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget);
    for (int i = 0; i < budget && int'(state) != s; i++) tick();
    check("wait_state", int'(state), s);
  endtask

  task automatic end_check(input string name, input int s, input int p, input int c);
    check({name, "_state"}, int'(state), s);
    check({name, "_pc"}, int'(pc), p);
    check({name, "_cnt"}, int'(issue_cnt), c);
    check({name, "_all_issued"}, exp_q.size(), 0);
  endtask

  task automatic reset_check(input string name);
    check({name, "_valid"}, int'(bus.instr_valid), 0);
    check({name, "_op"}, int'(bus.instr_op), 0);
    check({name, "_arg"}, int'(bus.instr_arg), 0);
    check({name, "_pc"}, int'(pc), 0);
    check({name, "_state"}, int'(state), 0);
    check({name, "_cnt"}, int'(issue_cnt), 0);
    check({name, "_err"}, int'(load_err), 0);
  endtask

  task automatic load_prog_a();
    for (int k = 0; k < 9; k++) load(k, {8'(k + 1), 8'(k + 1)});
    load(9, 16'h0000);
  endtask

  int n0;

  initial begin
    rst = 1'b1;
    start = 0; step_mode = 0; halt_req = 0; abort = 0; brk_en = 0; brk_addr = '0;
    bus.load_we = 0; bus.load_addr = '0; bus.load_data = '0; bus.core_ready = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    tick();
    tick();
    reset_check("reset");
    rst = 1'b0;
    tick();

    // Free run of program A at full rate.
    load_prog_a();
    bus.core_ready = 1'b1;
    model_run(0, 0, 0, 0, 0);
    gap_en = 1; last_x = -1;
    n0 = n_xfer;
    pulse_start();
    wait_state(4, 60);
    gap_en = 0;
    end_check("run", 4, 9, 10);
    check("run_nxfer", n_xfer - n0, 10);

    // Stall the 2nd instruction for 3 cycles.
    model_run(0, 0, 0, 0, 0);
    n0 = n_xfer;
    pulse_start();
    for (int i = 0; i < 20 && !(bus.instr_valid && bus.instr_op == 8'h02); i++) tick();
    bus.core_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_valid", int'(bus.instr_valid), 1);
      check("stall_hold_op", int'(bus.instr_op), 2);
    end
    bus.core_ready = 1'b1;
    wait_state(4, 60);
    end_check("stall", 4, 9, 10);
    check("stall_nxfer", n_xfer - n0, 10);

    // Single step three times.
    step_mode = 1'b1;
    for (int s = 0; s < 3; s++) begin
      model_run(s, s, 1, 0, 0);
      pulse_start();
      wait_state(3, 20);
      end_check("step", 3, s + 1, s + 1);
    end
    step_mode = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    end_check("abort_halt", 0, 0, 3);

    // Breakpoint at 4, then resume to completion.
    brk_en = 1'b1;
    brk_addr = 4'd4;
    model_run(0, 0, 0, 1, 4);
    pulse_start();
    wait_state(3, 40);
    end_check("brk", 3, 4, 4);
    model_run(4, 4, 0, 1, 4);
    pulse_start();
    wait_state(4, 40);
    end_check("brk_resume", 4, 9, 10);
    brk_en = 1'b0;

    // halt_req seen in FETCH halts without issuing.
    halt_req = 1'b1;
    pulse_start();
    wait_state(3, 10);
    end_check("halt_req", 3, 0, 0);
    halt_req = 1'b0;
    model_run(0, 0, 0, 0, 0);
    pulse_start();
    wait_state(4, 60);
    end_check("halt_resume", 4, 9, 10);

    // Write during ISSUE is dropped and flags load_err.
    bus.core_ready = 1'b0;
    model_run(0, 0, 0, 0, 0);
    pulse_start();
    wait_state(2, 10);
    bus.load_we = 1'b1; bus.load_addr = 4'd5; bus.load_data = 16'hAAAA;
    tick();
    bus.load_we = 1'b0;
    check("load_err_set", int'(load_err), 1);
    bus.core_ready = 1'b1;
    wait_state(4, 60);
    end_check("load_err_run", 4, 9, 10);
    check("load_err_sticky", int'(load_err), 1);

    // Abort mid-handshake.
    bus.core_ready = 1'b0;
    model_run(0, 0, 0, 0, 0);
    pulse_start();
    wait_state(2, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("abort_valid", int'(bus.instr_valid), 0);
    end_check("abort", 0, 0, 0);

    // Full store, no wrap past the last slot.
    bus.core_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) load(k, {8'(8'h10 + k), 8'(8'hF0 ^ k)});
    model_run(0, 0, 0, 0, 0);
    pulse_start();
    wait_state(4, 80);
    end_check("full", 4, 15, 16);

    // Reset mid-run.
    model_run(0, 0, 0, 0, 0);
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    reset_check("rst_mid");
    rst = 1'b0;
    tick();

    // Write and start in the same cycle: FETCH sees the new word.
    mem_m[0] = 16'h3344;
    model_run(0, 0, 0, 0, 0);
    bus.load_we = 1'b1; bus.load_addr = 4'd0; bus.load_data = 16'h3344;
    start = 1'b1;
    tick();
    bus.load_we = 1'b0;
    start = 1'b0;
    wait_state(4, 20);
    end_check("wr_start", 4, 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/minirisc_seq.md
# minirisc_seq

Program sequencer for the `tt_um_minirisc` accumulator core. It holds a small instruction store that is loaded over a write port. It then issues the stored instructions to the core one at a time over a valid/ready handshake, and supports free-run, single-step, breakpoint and halt/resume control. It sits between the host or test harness and the core's 8-bit opcode and operand inputs, replacing hand-driven `ui_in`/`uio_in` sequencing.

## Interface
Parameters:
- `DEPTH`, default 16: number of instruction slots; a power of 2, minimum 4.
- `AW`, default `$clog2(DEPTH)`: program-counter and address width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_we`  in  1  write strobe for the instruction store.
- `load_addr`  in  AW  write address.
- `load_data`  in  16  instruction: [15:8] opcode, [7:0] operand.
- `start`  in  1  pulse; starts from address 0 in IDLE/DONE, resumes in HALT.
- `step_mode`  in  1  when 1, enter HALT after each issued instruction.
- `halt_req`  in  1  level request to stop at the next instruction boundary.
- `abort`  in  1  pulse; return to IDLE from any state.
- `brk_en`  in  1  breakpoint enable.
- `brk_addr`  in  AW  breakpoint address; halts before this instruction is issued.
- `instr_valid`  out  1  an instruction is presented to the core.
- `instr_op`  out  8  opcode, drives core `ui_in`.
- `instr_arg`  out  8  operand, drives core `uio_in`.
- `core_ready`  in  1  the core accepts the instruction this cycle.
- `pc`  out  AW  address of the next instruction to issue.
- `state`  out  3  IDLE=0, FETCH=1, ISSUE=2, HALT=3, DONE=4.
- `issue_cnt`  out  8  instructions issued since the last start from address 0; wraps.
- `load_err`  out  1  sticky: a write was attempted while running.

## Operation
- The store is a DEPTH x 16 register array. Reset clears every entry to 0. Opcode 0x00 is HALT-PROGRAM.
- Writes take effect when `load_we` = 1 and state is IDLE, HALT or DONE.
  - A write in FETCH or ISSUE is dropped and sets `load_err`.
  - `load_err` clears only on `rst`.
- IDLE: on `start`, set `pc` = 0 and `issue_cnt` = 0, then go to FETCH.
- FETCH: register `mem[pc]` into `instr_op`/`instr_arg`.
  - If `halt_req` = 1, go to HALT without issuing.
  - Otherwise go to ISSUE.
- ISSUE: `instr_valid` = 1. A transfer occurs on the cycle where `core_ready` = 1. On transfer:
  - `issue_cnt` += 1 and `instr_valid` drops.
  - If the opcode is 0x00, go to DONE; `pc` holds.
  - Else if `pc` = DEPTH-1, go to DONE with `pc` = DEPTH-1; there is no wrap.
  - Otherwise `pc` += 1, then the first matching rule applies:
    - `step_mode` = 1 → HALT.
    - `halt_req` = 1 → HALT.
    - `brk_en` = 1 and new `pc` = `brk_addr` → HALT.
    - Otherwise → FETCH.
- HALT: outputs are idle and `pc` holds. On `start`, go to FETCH at the current `pc`; `issue_cnt` holds.
  - A breakpoint at the resumed `pc` does not re-trigger until another instruction has issued.
- DONE: on `start`, restart as from IDLE.
- `abort` applies in any state and has priority over all other inputs except `rst`:
  - Next state is IDLE, `instr_valid` = 0, `pc` = 0.
  - `issue_cnt` holds its value.
- Priority within a cycle: `rst` > `abort` > `start` > handshake/control.

## Timing
- Reset values:
  - `instr_valid` = 0, `instr_op` = 0, `instr_arg` = 0.
  - `pc` = 0, `state` = IDLE, `issue_cnt` = 0, `load_err` = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` at edge N → FETCH at N+1 → `instr_valid` = 1 at N+2.
- With `core_ready` held at 1, one instruction issues every 2 cycles (FETCH plus ISSUE).
- Handshake rules:
  - Once `instr_valid` = 1, it and `instr_op`/`instr_arg` stay stable until transfer. `abort` and `rst` are the only exceptions.
  - `core_ready` is sampled only in ISSUE.
- A write and `start` in the same cycle (IDLE): the write lands first, and the FETCH one cycle later sees the new data.
- `halt_req` is sampled only in FETCH and at a transfer; it never cuts a pending handshake short.

## Test plan
- Load mem[0..9] = {01,01},{02,02},…,{09,09},{00,00} with `core_ready` = 1, then pulse `start`.
  - Required: 10 transfers at 2-cycle spacing with op/arg 01..09 then 00.
  - Ends in DONE with `pc` = 9 and `issue_cnt` = 10.
- Same program with `core_ready` held low for 3 cycles on the 2nd instruction.
  - Required: `instr_valid` stays at 1 with op = 02 throughout the stall.
  - Exactly one transfer of 02 occurs; total `issue_cnt` = 10.
- `step_mode` = 1, then pulse `start` three times.
  - Required: HALT after each issue with `pc` = 1, 2, 3 and `issue_cnt` = 1, 2, 3.
- `brk_en` = 1, `brk_addr` = 4, then `start`.
  - Required: HALT with `pc` = 4 and `issue_cnt` = 4.
  - A second `start` resumes at 4 and runs to DONE.
- Store filled with nonzero opcodes in all 16 slots.
  - Required: DONE after slot 15, `pc` = 15, `issue_cnt` = 16, no wrap.
- `load_we` during ISSUE.
  - Required: the write is dropped and `load_err` = 1.
- `abort` mid-handshake.
  - Required: `instr_valid` = 0 and state IDLE next cycle.
- `rst` mid-run.
  - Required: all outputs return to their reset values.
